// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer
// Circular trace buffer for pipeline debug. Each captured entry holds CH
// channels of DATA_W bits (ch0 = pc, ch1 = instr). A trigger on ch0 moves the
// buffer into a post-trigger phase that records post_cnt more entries and then
// freezes the contents for readout.
//
// Optional feature: define TRACE_TIMESTAMP_EN to keep a 32-bit free-running
// cycle counter that is stored with every entry and returned on rd_ts.
//
// Ports
//   clk, rst        : single rising-edge clock, synchronous active-high reset
//   ena             : global enable, low holds all state
//   clr             : empty the buffer and rearm (only when ena=1)
//   cap_valid       : cap_data carries an entry this cycle
//   cap_data        : entry to capture, ch0 in [DATA_W-1:0]
//   trig_en         : enable the ch0 == trig_val compare
//   trig_val        : ch0 trigger value
//   post_cnt        : entries captured after the trigger entry
//   rd_addr         : read index, 0 = oldest valid entry
//   rd_data, rd_ts  : registered read data / timestamp, one cycle after rd_addr
//   count           : valid entries, saturating at DEPTH
//   state           : 00 IDLE, 01 ARMED, 10 POST, 11 FROZEN
//
// Handshake: cap_valid has no ready; an entry is taken in every cycle with
// ena=1, clr=0, cap_valid=1 and state ARMED or POST, and dropped otherwise.
module pipe_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int CH     = 2,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 clr,
  input  logic                 cap_valid,
  input  logic [CH*DATA_W-1:0] cap_data,
  input  logic                 trig_en,
  input  logic [DATA_W-1:0]    trig_val,
  input  logic [AW-1:0]        post_cnt,
  input  logic [AW-1:0]        rd_addr,
  output logic [CH*DATA_W-1:0] rd_data,
  output logic [31:0]          rd_ts,
  output logic [AW:0]          count,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ARMED  = 2'b01,
    S_POST   = 2'b10,
    S_FROZEN = 2'b11
  } state_e;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_e                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [AW-1:0]         post_q, post_d;
  logic [CH*DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [31:0]           rd_ts_q, rd_ts_d;
  logic                  wr_en;
  logic                  trig_hit;
  logic [AW-1:0]         oldest;
  logic [AW-1:0]         rd_idx;
  logic                  rd_in_range;

  logic [CH*DATA_W-1:0]  mem_q [DEPTH];

  // Pointer minus count gives the oldest slot; when full the low AW bits of
  // count are zero so this is the write pointer itself.
  assign oldest      = wr_ptr_q - count_q[AW-1:0];
  assign rd_idx      = oldest + rd_addr;
  assign rd_in_range = ({1'b0, rd_addr} < count_q);
  assign trig_hit    = trig_en && (cap_data[DATA_W-1:0] == trig_val);
  assign wr_en       = ena && !clr && cap_valid &&
                       ((state_q == S_ARMED) || (state_q == S_POST));

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;
  logic [31:0] ts_mem_q [DEPTH];

  always_comb begin
    ts_d = ts_q;
    if (ena) ts_d = ts_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) ts_mem_q[wr_ptr_q] <= ts_q;
  end

  always_comb begin
    rd_ts_d = rd_ts_q;
    if (ena) rd_ts_d = rd_in_range ? ts_mem_q[rd_idx] : 32'd0;
  end
`else
  always_comb begin
    rd_ts_d = 32'd0;
  end
`endif

  // Storage is not reset; the read mux returns zero outside the valid range.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= cap_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (ena) rd_data_d = rd_in_range ? mem_q[rd_idx] : '0;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    post_d   = post_q;
    if (ena) begin
      if (clr) begin
        state_d  = S_ARMED;
        wr_ptr_d = '0;
        count_d  = '0;
        post_d   = '0;
      end else begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (count_q != FULL) count_d = count_q + 1'b1;
        end
        unique case (state_q)
          S_IDLE:  state_d = S_ARMED;
          S_ARMED: begin
            if (cap_valid && trig_hit) begin
              post_d  = post_cnt;
              state_d = (post_cnt == '0) ? S_FROZEN : S_POST;
            end
          end
          S_POST: begin
            if (cap_valid) begin
              post_d = post_q - 1'b1;
              if (post_q == {{(AW-1){1'b0}}, 1'b1}) state_d = S_FROZEN;
            end
          end
          S_FROZEN: state_d = S_FROZEN;
          default:  state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      post_q    <= '0;
      rd_data_q <= '0;
      rd_ts_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      post_q    <= post_d;
      rd_data_q <= rd_data_d;
      rd_ts_q   <= rd_ts_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_ts   = rd_ts_q;
  assign count   = count_q;
  assign state   = state_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed testbench for pipe_trace_buffer at default parameters
// (DATA_W=32, CH=2, DEPTH=16). Inputs change #1 after the rising edge and
// outputs are checked there, away from the next sampling edge.
module tb_pipe_trace_buffer;

  localparam int DATA_W = 32;
  localparam int CH     = 2;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ARMED  = 2'b01;
  localparam logic [1:0] ST_POST   = 2'b10;
  localparam logic [1:0] ST_FROZEN = 2'b11;

  logic                 clk;
  logic                 rst;
  logic                 ena;
  logic                 clr;
  logic                 cap_valid;
  logic [CH*DATA_W-1:0] cap_data;
  logic                 trig_en;
  logic [DATA_W-1:0]    trig_val;
  logic [AW-1:0]        post_cnt;
  logic [AW-1:0]        rd_addr;
  logic [CH*DATA_W-1:0] rd_data;
  logic [31:0]          rd_ts;
  logic [AW:0]          count;
  logic [1:0]           state;

  int n_checks;
  int n_errors;

  pipe_trace_buffer #(.DATA_W(DATA_W), .CH(CH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .clr       (clr),
    .cap_valid (cap_valid),
    .cap_data  (cap_data),
    .trig_en   (trig_en),
    .trig_val  (trig_val),
    .post_cnt  (post_cnt),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_ts     (rd_ts),
    .count     (count),
    .state     (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CH*DATA_W-1:0] mk_entry(input logic [31:0] pc);
    return {pc ^ 32'hA5A5_0000, pc};
  endfunction

  task automatic cap(input logic [31:0] pc);
    cap_valid = 1'b1;
    cap_data  = mk_entry(pc);
    tick();
    cap_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic read_at(input logic [AW-1:0] a);
    rd_addr = a;
    tick();
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] ts_a;
  logic [31:0] ts_b;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    ena       = 1'b0;
    clr       = 1'b0;
    cap_valid = 1'b0;
    cap_data  = '0;
    trig_en   = 1'b0;
    trig_val  = '0;
    post_cnt  = '0;
    rd_addr   = '0;

    // Reset state
    do_reset();
    check("rst_state", 64'(state), 64'(ST_IDLE));
    check("rst_count", 64'(count), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_rd_ts", 64'(rd_ts), 64'd0);

    // First enabled cycle arms; five untriggered captures
    ena = 1'b1;
    tick();
    check("arm_state", 64'(state), 64'(ST_ARMED));
    for (int k = 0; k < 5; k++) cap(32'h0040_0000 + 32'(4 * k));
    check("five_count", 64'(count), 64'd5);
    check("five_state", 64'(state), 64'(ST_ARMED));
    read_at(4'd2);
    check("five_rd2_pc", 64'(rd_data[31:0]), 64'h0040_0008);
    check("five_rd2_instr", 64'(rd_data[63:32]), 64'(32'h0040_0008 ^ 32'hA5A5_0000));
    read_at(4'd5);
    check("five_rd_oob", rd_data, 64'd0);

    // Wrap: 20 captures into 16 entries
    do_clr();
    check("clr_count", 64'(count), 64'd0);
    for (int k = 0; k < 20; k++) cap(32'h0000_1000 + 32'(k));
    check("wrap_count", 64'(count), 64'd16);
    read_at(4'd0);
    check("wrap_rd0", rd_data, mk_entry(32'h0000_1004));
    read_at(4'd15);
    check("wrap_rd15", rd_data, mk_entry(32'h0000_1013));

    // Trigger at 0x0040000C with post_cnt=3
    do_clr();
    read_at(4'd3);
    check("clr_rd_oob", rd_data, 64'd0);
    trig_en  = 1'b1;
    trig_val = 32'h0040_000C;
    post_cnt = 4'd3;
    for (int k = 0; k < 4; k++) cap(32'h0040_0000 + 32'(4 * k));
    check("trig_post", 64'(state), 64'(ST_POST));
    for (int k = 4; k < 7; k++) cap(32'h0040_0000 + 32'(4 * k));
    check("trig_frozen", 64'(state), 64'(ST_FROZEN));
    check("trig_count", 64'(count), 64'd7);
    for (int k = 7; k < 10; k++) cap(32'h0040_0000 + 32'(4 * k));
    check("frozen_state", 64'(state), 64'(ST_FROZEN));
    check("frozen_count", 64'(count), 64'd7);
    read_at(4'd6);
    check("frozen_last", 64'(rd_data[31:0]), 64'h0040_0018);
    read_at(4'd3);
    check("frozen_trig", 64'(rd_data[31:0]), 64'h0040_000C);

    // post_cnt=0, trigger on first capture
    do_clr();
    check("rearm_state", 64'(state), 64'(ST_ARMED));
    trig_val = 32'h0040_0000;
    post_cnt = 4'd0;
    cap(32'h0040_0000);
    check("pc0_state", 64'(state), 64'(ST_FROZEN));
    check("pc0_count", 64'(count), 64'd1);

    // clr together with a triggering capture
    clr = 1'b1;
    cap(32'h0040_0000);
    clr = 1'b0;
    check("clr_trig_state", 64'(state), 64'(ST_ARMED));
    check("clr_trig_count", 64'(count), 64'd0);

    // rst mid-POST
    post_cnt = 4'd5;
    cap(32'h0040_0000);
    cap(32'h0040_0004);
    check("midpost_state", 64'(state), 64'(ST_POST));
    rst = 1'b1;
    cap(32'h0040_0008);
    rst = 1'b0;
    check("midpost_rst_state", 64'(state), 64'(ST_IDLE));
    check("midpost_rst_count", 64'(count), 64'd0);

    // ena=0 holds everything for 3 cycles
    trig_en = 1'b0;
    tick();
    cap(32'h0000_2000);
    cap(32'h0000_2004);
    ena       = 1'b0;
    clr       = 1'b1;
    cap_valid = 1'b1;
    cap_data  = mk_entry(32'h0000_2008);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_state", 64'(state), 64'(ST_ARMED));
      check("hold_count", 64'(count), 64'd2);
    end
    clr       = 1'b0;
    cap_valid = 1'b0;
    ena       = 1'b1;

    // Timestamps: two captures three cycles apart
    do_reset();
    tick();
    cap(32'h0000_3000);
    tick();
    tick();
    cap(32'h0000_3004);
    read_at(4'd0);
    ts_a = rd_ts;
    read_at(4'd1);
    ts_b = rd_ts;
`ifdef TRACE_TIMESTAMP_EN
    check("ts_delta", 64'(ts_b - ts_a), 64'd3);
`else
    check("ts_zero_a", 64'(ts_a), 64'd0);
    check("ts_zero_b", 64'(ts_b), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_trace_buffer.md
PIPE_TRACE_BUFFER -- requirements
Module: pipe_trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one captured channel.
REQ-002 SHALL have parameter CH, default 2, channels per entry (ch0 = pc, ch1 = instr).
REQ-003 SHALL have parameter DEPTH, default 16, power of two >= 2; AW = log2(DEPTH).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port ena  in  1  global enable; low = hold all state.
REQ-007 SHALL have port clr  in  1  empty buffer, rearm.
REQ-008 SHALL have port cap_valid  in  1  cap_data is valid this cycle.
REQ-009 SHALL have port cap_data  in  CH*DATA_W  entry to capture; ch0 in bits [DATA_W-1:0].
REQ-010 SHALL have port trig_en  in  1  trigger compare enable.
REQ-011 SHALL have port trig_val  in  DATA_W  ch0 match value.
REQ-012 SHALL have port post_cnt  in  AW  entries captured after the trigger entry.
REQ-013 SHALL have port rd_addr  in  AW  read index, 0 = oldest valid entry.
REQ-014 SHALL have port rd_data  out  CH*DATA_W  registered read data.
REQ-015 SHALL have port rd_ts  out  32  registered timestamp of the read entry.
REQ-016 SHALL have port count  out  AW+1  valid entries, saturating at DEPTH.
REQ-017 SHALL have port state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 FROZEN.

Function
REQ-018 SHALL store an entry at the write pointer, then increment it mod DEPTH, in each cycle with ena=1, cap_valid=1 and state ARMED or POST.
REQ-019 SHALL, when full, overwrite the oldest entry; count stays DEPTH and the oldest index advances by one.
REQ-020 SHALL move IDLE->ARMED on the first cycle with ena=1.
REQ-021 SHALL move ARMED->POST when a capture occurs with trig_en=1 and cap_data[DATA_W-1:0]==trig_val; the triggering entry is stored.
REQ-022 SHALL, at trigger, load a post counter with post_cnt; each POST capture decrements it; POST->FROZEN on the capture that brings it to 0.
REQ-023 SHALL, with post_cnt=0, go ARMED->FROZEN directly on the trigger capture.
REQ-024 SHALL perform no writes in FROZEN; FROZEN holds until clr or rst.
REQ-025 SHALL, on clr with ena=1, set count=0 and write pointer=0, and enter ARMED from any state; clr overrides a same-cycle trigger or capture.
REQ-026 SHALL, with ena=0, ignore cap_valid and clr and hold state, count and pointers.
REQ-027 SHALL present rd_data one cycle after rd_addr from entry (oldest+rd_addr) mod DEPTH, in every state.
REQ-028 SHALL return rd_data=0 and rd_ts=0 when rd_addr >= count.
REQ-029 SHALL give a same-cycle write and read of one entry old-data (read-before-write) behaviour.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set state=IDLE, count=0, write pointer=0, post counter=0, rd_data=0 and rd_ts=0; entry storage need not be cleared.
REQ-031 SHALL give rst priority over ena, clr and capture, including mid-POST.

Configuration
REQ-032 SHALL, with TRACE_TIMESTAMP_EN defined, keep a 32-bit free-running cycle counter (0 at reset, wraps) that counts on ena=1, store it with every entry and output it on rd_ts.
REQ-033 SHALL, with TRACE_TIMESTAMP_EN undefined, omit the counter and timestamp storage and tie rd_ts to 0.

Verification
REQ-034 SHALL cover: reset, then 5 captures of pc=0x00400000+4k with trig_en=0 -> count=5, state=ARMED, rd_addr=2 gives pc 0x00400008 one cycle later.
REQ-035 SHALL cover: 20 captures at DEPTH=16 -> count=16, rd_addr=0 gives entry #4, rd_addr=15 gives entry #19.
REQ-036 SHALL cover: trig_val=0x0040000C, post_cnt=3, stream from 0x00400000 -> FROZEN after capturing 0x00400018; later cap_valid changes nothing.
REQ-037 SHALL cover: post_cnt=0 with the trigger on the 1st capture -> FROZEN the next cycle with count=1, and clr asserted together with a trigger -> ARMED with count=0.
REQ-038 SHALL cover: rst asserted mid-POST -> IDLE and count=0 the next cycle; with ena=0 for 3 cycles, state and count stay unchanged.
REQ-039 SHALL cover, with TRACE_TIMESTAMP_EN: captures on cycles 10 and 13 after reset -> rd_ts differs by 3; without the macro, rd_ts=0 always.
